// File: rtl/uart_pkg.sv
// Shared definitions for the UART host bridge: handshake FSM encodings and
// the fixed width of the configuration bus toward the UART core.
package uart_pkg;

  localparam int CONF_BUS_W = 32;

  typedef enum logic [1:0] {
    INIT_IDLE   = 2'd0,
    INIT_REQ_HI = 2'd1,
    INIT_REQ_LO = 2'd2
  } init_state_t;

  typedef enum logic {
    RESP_WAIT_REQ = 1'b0,
    RESP_ACK_HI   = 1'b1
  } resp_state_t;

endpackage

// File: rtl/uart_hs_init.sv
// 4-phase handshake initiator: accepts one word from a valid/ready host stream
// and delivers it across a clock-domain boundary with req/ack.
module uart_hs_init
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SYNC_STAGE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              req,
  input  logic              ack,
  output logic [DATA_W-1:0] out_data
);

  logic [SYNC_STAGE-1:0] ack_sync;
  logic                  ack_s;
  logic                  load;
  init_state_t           state;
  init_state_t           state_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync[0] <= ack;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        ack_sync[i] <= ack_sync[i-1];
      end
    end
  end

  assign ack_s = ack_sync[SYNC_STAGE-1];

  // req and data are registered so the peer never sees decode glitches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT_IDLE;
      req      <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_next;
      req   <= (state_next == INIT_REQ_HI);
      if (load) begin
        out_data <= data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT_IDLE:   if (valid) state_next = INIT_REQ_HI;
      INIT_REQ_HI: if (ack_s) state_next = INIT_REQ_LO;
      INIT_REQ_LO: if (!ack_s) state_next = INIT_IDLE;
      default:     state_next = INIT_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == INIT_IDLE);
    load  = ready && valid;
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side bridge to an asynchronous UART core: tx and config initiators plus
// an rx responder with a one-entry output buffer and backpressure.
module uart_host_bridge
  import uart_pkg::*;
#(
  parameter int UART_DATA_WIDTH = 8,
  parameter int CONFIG_WIDTH    = 8,
  parameter int SYNC_STAGE      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_perr,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CONFIG_WIDTH-1:0]    cfg_data,
  output logic                       async_tx_d_req,
  input  logic                       async_tx_d_ack,
  output logic [UART_DATA_WIDTH-1:0] async_tx_d,
  input  logic                       async_rx_d_req,
  output logic                       async_rx_d_ack,
  input  logic [UART_DATA_WIDTH:0]   async_rx_d,
  output logic                       async_conf_req,
  input  logic                       async_conf_ack,
  output logic [CONF_BUS_W-1:0]      async_conf
);

  uart_hs_init #(
    .DATA_W     (UART_DATA_WIDTH),
    .SYNC_STAGE (SYNC_STAGE)
  ) u_tx_init (
    .clock    (clock),
    .reset    (reset),
    .valid    (tx_valid),
    .ready    (tx_ready),
    .data     (tx_data),
    .req      (async_tx_d_req),
    .ack      (async_tx_d_ack),
    .out_data (async_tx_d)
  );

  uart_hs_init #(
    .DATA_W     (CONF_BUS_W),
    .SYNC_STAGE (SYNC_STAGE)
  ) u_conf_init (
    .clock    (clock),
    .reset    (reset),
    .valid    (cfg_valid),
    .ready    (cfg_ready),
    .data     (CONF_BUS_W'(cfg_data)),
    .req      (async_conf_req),
    .ack      (async_conf_ack),
    .out_data (async_conf)
  );

  logic [SYNC_STAGE-1:0] req_sync;
  logic                  req_s;
  logic                  capture;
  resp_state_t           rx_state;
  resp_state_t           rx_state_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_sync <= '0;
    end else begin
      req_sync[0] <= async_rx_d_req;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        req_sync[i] <= req_sync[i-1];
      end
    end
  end

  assign req_s = req_sync[SYNC_STAGE-1];

  // async_rx_d is bundled data: stable by the time req has crossed the synchronizer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state       <= RESP_WAIT_REQ;
      async_rx_d_ack <= 1'b0;
      rx_valid       <= 1'b0;
      rx_data        <= '0;
      rx_perr        <= 1'b0;
    end else begin
      rx_state       <= rx_state_next;
      async_rx_d_ack <= (rx_state_next == RESP_ACK_HI);
      if (capture) begin
        rx_data  <= async_rx_d[UART_DATA_WIDTH-1:0];
        rx_perr  <= async_rx_d[UART_DATA_WIDTH];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RESP_WAIT_REQ: if (req_s && (!rx_valid || rx_ready)) rx_state_next = RESP_ACK_HI;
      RESP_ACK_HI:   if (!req_s) rx_state_next = RESP_WAIT_REQ;
      default:       rx_state_next = RESP_WAIT_REQ;
    endcase
  end

  always_comb begin
    capture = (rx_state == RESP_WAIT_REQ) && (rx_state_next == RESP_ACK_HI);
  end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: auto-ack peers, a driven rx
// initiator, and a tx->rx loopback mode with queue-based reference model.
`timescale 1ns/1ps
module tb_uart_host_bridge;
  import uart_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int SS = 2;
  localparam int TO = 200;

  logic          clock = 1'b0;
  logic          reset;
  logic          tx_valid, tx_ready;
  logic [W-1:0]  tx_data;
  logic          rx_valid, rx_ready, rx_perr;
  logic [W-1:0]  rx_data;
  logic          cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          async_tx_d_req, async_tx_d_ack;
  logic [W-1:0]  async_tx_d;
  logic          async_rx_d_req, async_rx_d_ack;
  logic [W:0]    async_rx_d;
  logic          async_conf_req, async_conf_ack;
  logic [31:0]   async_conf;

  logic          loopback;
  logic          drv_rx_req;
  logic [W:0]    drv_rx_d;
  logic [1:0]    tx_peer, conf_peer;
  logic          tx_req_q, conf_req_q;

  int checks   = 0;
  int failures = 0;

  logic [W:0]   rx_got[$];
  logic [W-1:0] tx_seen[$];
  logic [31:0]  conf_seen[$];

  always #5 clock = ~clock;

  uart_host_bridge #(
    .UART_DATA_WIDTH (W),
    .CONFIG_WIDTH    (CW),
    .SYNC_STAGE      (SS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_perr        (rx_perr),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_data       (cfg_data),
    .async_tx_d_req (async_tx_d_req),
    .async_tx_d_ack (async_tx_d_ack),
    .async_tx_d     (async_tx_d),
    .async_rx_d_req (async_rx_d_req),
    .async_rx_d_ack (async_rx_d_ack),
    .async_rx_d     (async_rx_d),
    .async_conf_req (async_conf_req),
    .async_conf_ack (async_conf_ack),
    .async_conf     (async_conf)
  );

  assign async_tx_d_ack = loopback ? async_rx_d_ack : tx_peer[1];
  assign async_rx_d_req = loopback ? async_tx_d_req : drv_rx_req;
  assign async_rx_d     = loopback ? {1'b0, async_tx_d} : drv_rx_d;
  assign async_conf_ack = conf_peer[1];

  // Peers ack two clocks after req and share the DUT reset; monitors record transfers.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_peer    <= '0;
      conf_peer  <= '0;
      tx_req_q   <= 1'b0;
      conf_req_q <= 1'b0;
    end else begin
      tx_peer    <= {tx_peer[0], async_tx_d_req & ~loopback};
      conf_peer  <= {conf_peer[0], async_conf_req};
      tx_req_q   <= async_tx_d_req;
      conf_req_q <= async_conf_req;
      if (async_tx_d_req && !tx_req_q && !loopback) tx_seen.push_back(async_tx_d);
      if (async_conf_req && !conf_req_q) conf_seen.push_back(async_conf);
      if (rx_valid && rx_ready) rx_got.push_back({rx_perr, rx_data});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({tx_ready, cfg_ready} !== 2'b11) begin
      failures++; $display("FAIL reset_ready: got %b want 11", {tx_ready, cfg_ready});
    end
    checks++;
    if ({async_tx_d_req, async_conf_req, async_rx_d_ack, rx_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_handshake: got %b want 0000",
                           {async_tx_d_req, async_conf_req, async_rx_d_ack, rx_valid});
    end
    checks++;
    if ({rx_perr, rx_data, async_tx_d, async_conf} !== '0) begin
      failures++; $display("FAIL reset_data: got perr=%b rx=%h tx=%h conf=%h want all 0",
                           rx_perr, rx_data, async_tx_d, async_conf);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({tx_ready, cfg_ready} !== 2'b11) begin
      failures++; $display("FAIL post_reset_ready: got %b want 11", {tx_ready, cfg_ready});
    end
  endtask

  task automatic test_tx_timing();
    int n;
    logic held;
    tx_data = 8'hA5; tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++; $display("FAIL tx_idle_ready: got %b want 1", tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    checks++;
    if ({async_tx_d_req, tx_ready, async_tx_d} !== {1'b1, 1'b0, 8'hA5}) begin
      failures++; $display("FAIL tx_launch: got req=%b ready=%b d=%h want 1 0 a5",
                           async_tx_d_req, tx_ready, async_tx_d);
    end
    held = 1'b1;
    n = 0;
    while (async_tx_d_ack !== 1'b1 && n < TO) begin
      tick(); n++;
    end
    n = 0;
    while (async_tx_d_req === 1'b1 && n < TO) begin
      if (async_tx_d !== 8'hA5 || tx_ready !== 1'b0) held = 1'b0;
      tick(); n++;
    end
    checks++;
    if (n !== SS + 1) begin
      failures++; $display("FAIL tx_req_fall: got %0d clocks after ack want %0d", n, SS + 1);
    end
    n = 0;
    while (async_tx_d_ack === 1'b1 && n < TO) begin
      if (async_tx_d !== 8'hA5 || tx_ready !== 1'b0 || async_tx_d_req !== 1'b0) held = 1'b0;
      tick(); n++;
    end
    n = 0;
    while (tx_ready !== 1'b1 && n < TO) begin
      if (async_tx_d !== 8'hA5 || async_tx_d_req !== 1'b0) held = 1'b0;
      tick(); n++;
    end
    checks++;
    if (n !== SS + 1) begin
      failures++; $display("FAIL tx_ready_return: got %0d clocks after ack low want %0d", n, SS + 1);
    end
    checks++;
    if (held !== 1'b1) begin
      failures++; $display("FAIL tx_hold: got held=%b want 1", held);
    end
    checks++;
    if (tx_seen.size() != 1 || tx_seen[0] !== 8'hA5) begin
      failures++; $display("FAIL tx_peer_data: got n=%0d want one byte a5", tx_seen.size());
    end
    tx_seen.delete();
  endtask

  task automatic test_cfg();
    logic [CW-1:0] v;
    logic ok, saw_ack;
    int n;
    for (int k = 0; k < 3; k++) begin
      v = (k == 0) ? 8'h62 : CW'($urandom);
      cfg_data = v; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (async_conf_req !== 1'b1) begin
        failures++; $display("FAIL cfg_launch: got req=%b want 1", async_conf_req);
      end
      ok = 1'b1; saw_ack = 1'b0; n = 0;
      while (cfg_ready !== 1'b1 && n < TO) begin
        if (async_conf !== {24'h0, v} || cfg_ready !== 1'b0) ok = 1'b0;
        if (async_conf_ack === 1'b1) saw_ack = 1'b1;
        tick(); n++;
      end
      checks++;
      if (ok !== 1'b1 || saw_ack !== 1'b1 || n >= TO) begin
        failures++; $display("FAIL cfg_handshake: got ok=%b ack_seen=%b clocks=%0d want 1 1 <%0d",
                             ok, saw_ack, n, TO);
      end
      checks++;
      if (conf_seen.size() != 1 || conf_seen[0] !== {24'h0, v}) begin
        failures++; $display("FAIL cfg_peer_data: got n=%0d want one word %h", conf_seen.size(), v);
      end
      conf_seen.delete();
    end
  endtask

  task automatic test_rx_single();
    int n;
    rx_ready = 1'b1;
    drv_rx_d = 9'h13C; drv_rx_req = 1'b1;
    n = 0;
    while (async_rx_d_ack !== 1'b1 && n < TO) begin
      tick(); n++;
    end
    checks++;
    if (n !== SS + 1) begin
      failures++; $display("FAIL rx_ack_rise: got %0d clocks want %0d", n, SS + 1);
    end
    checks++;
    if ({rx_valid, rx_perr, rx_data} !== {1'b1, 1'b1, 8'h3C}) begin
      failures++; $display("FAIL rx_capture: got v=%b perr=%b d=%h want 1 1 3c", rx_valid, rx_perr, rx_data);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++; $display("FAIL rx_drain: got rx_valid=%b want 0", rx_valid);
    end
    drv_rx_req = 1'b0;
    n = 0;
    while (async_rx_d_ack !== 1'b0 && n < TO) begin
      tick(); n++;
    end
    checks++;
    if (n !== SS + 1) begin
      failures++; $display("FAIL rx_ack_fall: got %0d clocks want %0d", n, SS + 1);
    end
    checks++;
    if (rx_got.size() != 1 || rx_got[0] !== 9'h13C) begin
      failures++; $display("FAIL rx_host_seq: got n=%0d want one entry 13c", rx_got.size());
    end
    rx_got.delete();
    rx_ready = 1'b0;
  endtask

  task automatic rx_send_full(input logic [W:0] d);
    int n;
    drv_rx_d = d; drv_rx_req = 1'b1;
    n = 0;
    while (async_rx_d_ack !== 1'b1 && n < TO) begin tick(); n++; end
    drv_rx_req = 1'b0;
    while (async_rx_d_ack !== 1'b0 && n < TO) begin tick(); n++; end
    checks++;
    if (n >= TO) begin
      failures++; $display("FAIL rx_send_timeout: got %0d clocks want <%0d", n, TO);
    end
  endtask

  task automatic test_backpressure();
    logic stalled;
    int n;
    rx_ready = 1'b0;
    rx_send_full({1'b0, 8'h11});
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
      failures++; $display("FAIL bp_first: got v=%b d=%h want 1 11", rx_valid, rx_data);
    end
    drv_rx_d = {1'b0, 8'h22}; drv_rx_req = 1'b1;
    stalled = 1'b1;
    for (int i = 0; i < 4 * (SS + 2); i++) begin
      tick();
      if (async_rx_d_ack !== 1'b0 || rx_data !== 8'h11 || rx_valid !== 1'b1) stalled = 1'b0;
    end
    checks++;
    if (stalled !== 1'b1) begin
      failures++; $display("FAIL bp_stall: got stalled=%b want 1", stalled);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++;
    if ({rx_valid, rx_data, async_rx_d_ack} !== {1'b1, 8'h22, 1'b1}) begin
      failures++; $display("FAIL bp_refill: got v=%b d=%h ack=%b want 1 22 1",
                           rx_valid, rx_data, async_rx_d_ack);
    end
    drv_rx_req = 1'b0;
    n = 0;
    while (async_rx_d_ack !== 1'b0 && n < TO) begin tick(); n++; end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++; $display("FAIL bp_final_drain: got rx_valid=%b want 0", rx_valid);
    end
    checks++;
    if (rx_got.size() != 2 || rx_got[0] !== 9'h011 || rx_got[1] !== 9'h022) begin
      failures++; $display("FAIL bp_order: got n=%0d want 011 then 022", rx_got.size());
    end
    rx_got.delete();
  endtask

  task automatic test_concurrent();
    logic [W-1:0]  t;
    logic [CW-1:0] c;
    int n;
    t = W'($urandom); c = CW'($urandom);
    tx_data = t; cfg_data = c; tx_valid = 1'b1; cfg_valid = 1'b1;
    tick();
    tx_valid = 1'b0; cfg_valid = 1'b0;
    checks++;
    if ({async_tx_d_req, async_conf_req, async_tx_d, async_conf} !== {1'b1, 1'b1, t, {24'h0, c}}) begin
      failures++; $display("FAIL conc_launch: got req=%b%b tx=%h conf=%h want 11 %h %h",
                           async_tx_d_req, async_conf_req, async_tx_d, async_conf, t, c);
    end
    n = 0;
    while (!(tx_ready === 1'b1 && cfg_ready === 1'b1) && n < TO) begin tick(); n++; end
    checks++;
    if (n >= TO || tx_seen.size() != 1 || conf_seen.size() != 1 ||
        tx_seen[0] !== t || conf_seen[0] !== {24'h0, c}) begin
      failures++; $display("FAIL conc_done: got clocks=%0d ntx=%0d ncfg=%0d want both delivered",
                           n, tx_seen.size(), conf_seen.size());
    end
    tx_seen.delete(); conf_seen.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    rx_ready = 1'b0;
    drv_rx_d = {1'b0, W'($urandom)}; drv_rx_req = 1'b1;
    n = 0;
    while (rx_valid !== 1'b1 && n < TO) begin tick(); n++; end
    tx_data = W'($urandom); tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if ({async_tx_d_req, rx_valid} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_setup: got req=%b rx_valid=%b want 1 1", async_tx_d_req, rx_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({async_tx_d_req, async_conf_req, async_rx_d_ack, rx_valid, tx_ready, cfg_ready} !== 6'b000011) begin
      failures++; $display("FAIL rst_mid_ctrl: got %b want 000011",
                           {async_tx_d_req, async_conf_req, async_rx_d_ack, rx_valid, tx_ready, cfg_ready});
    end
    checks++;
    if ({rx_perr, rx_data, async_tx_d} !== '0) begin
      failures++; $display("FAIL rst_mid_data: got perr=%b rx=%h tx=%h want 0", rx_perr, rx_data, async_tx_d);
    end
    drv_rx_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tx_seen.delete(); rx_got.delete(); conf_seen.delete();
  endtask

  task automatic test_loopback();
    logic [W:0] exp_q[$];
    logic [W-1:0] b;
    int n, sent;
    cfg_data = 8'h62; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n = 0;
    while (cfg_ready !== 1'b1 && n < TO) begin tick(); n++; end
    checks++;
    if (conf_seen.size() != 1 || conf_seen[0] !== 32'h0000_0062) begin
      failures++; $display("FAIL loop_cfg: got n=%0d want one word 62", conf_seen.size());
    end
    loopback = 1'b1;
    sent = 0; n = 0;
    while (rx_got.size() < 16 && n < 5000) begin
      rx_ready = 1'($urandom_range(0, 1));
      if (sent < 16 && tx_ready === 1'b1) begin
        b = W'($urandom);
        tx_data = b; tx_valid = 1'b1;
        exp_q.push_back({1'b0, b});
        sent++;
      end else begin
        tx_valid = 1'b0;
      end
      tick(); n++;
    end
    tx_valid = 1'b0; rx_ready = 1'b0;
    checks++;
    if (rx_got.size() != 16) begin
      failures++; $display("FAIL loop_count: got %0d bytes want 16", rx_got.size());
    end
    for (int i = 0; i < 16 && i < rx_got.size(); i++) begin
      checks++;
      if (rx_got[i] !== exp_q[i]) begin
        failures++; $display("FAIL loop_byte%0d: got %h want %h", i, rx_got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    loopback = 1'b0;
    drv_rx_req = 1'b0; drv_rx_d = '0;
    test_reset();
    test_tx_timing();
    test_cfg();
    test_rx_single();
    test_backpressure();
    test_concurrent();
    test_reset_mid();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_host_bridge.md
UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 SHALL have parameter UART_DATA_WIDTH, default 8, defining the data byte width W.
REQ-002 SHALL have parameter CONFIG_WIDTH, default 8, defining the significant config bits.
REQ-003 SHALL have parameter SYNC_STAGE, default 2, defining the flop depth of every async-input synchronizer.
REQ-004 SHALL have port clock  in  1  sole clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports tx_valid in 1, tx_ready out 1, tx_data in W  host transmit stream.
REQ-007 SHALL have ports rx_valid out 1, rx_ready in 1, rx_data out W, rx_perr out 1  host receive stream plus parity-error flag.
REQ-008 SHALL have ports cfg_valid in 1, cfg_ready out 1, cfg_data in CONFIG_WIDTH  host config write.
REQ-009 SHALL have ports async_tx_d_req out 1, async_tx_d_ack in 1, async_tx_d out W  4-phase initiator to the UART transmitter.
REQ-010 SHALL have ports async_rx_d_req in 1, async_rx_d_ack out 1, async_rx_d in W+1  4-phase responder to the UART receiver; bit W is the parity-error flag.
REQ-011 SHALL have ports async_conf_req out 1, async_conf_ack in 1, async_conf out 32  4-phase config initiator; upper 32-CONFIG_WIDTH bits zero.

Function
REQ-012 SHALL pass async_tx_d_ack, async_conf_ack and async_rx_d_req each through a SYNC_STAGE-flop synchronizer before any use.
REQ-013 SHALL run each initiator (tx, conf) as FSM IDLE -> REQ_HI -> REQ_LO -> IDLE.
REQ-014 IDLE: ready=1; on valid&ready, SHALL register data onto async_*_d and assert req on the next edge, entering REQ_HI.
REQ-015 REQ_HI: req=1 and data SHALL stay constant; on synced ack=1, SHALL deassert req next edge and enter REQ_LO.
REQ-016 REQ_LO: req=0, data held; on synced ack=0, SHALL return to IDLE; ready=0 in REQ_HI and REQ_LO.
REQ-017 Tx and conf channels SHALL be independent and may handshake concurrently; ordering between them is host responsibility.
REQ-018 Responder FSM WAIT_REQ -> ACK_HI -> WAIT_REQ: in WAIT_REQ, when synced req=1 and the output buffer is free or being drained this cycle (!rx_valid | rx_ready), SHALL capture async_rx_d into rx_data/rx_perr, set rx_valid and assert async_rx_d_ack, entering ACK_HI.
REQ-019 If the buffer is full and not drained, SHALL hold ack=0 (backpressure); no received byte SHALL ever be dropped or overwritten.
REQ-020 ACK_HI: on synced req=0, SHALL deassert ack next edge and return to WAIT_REQ.
REQ-021 rx_valid SHALL clear on rx_valid&rx_ready unless a new capture occurs in the same cycle, in which case it stays 1 with new data.
REQ-022 Minimum round trip per transfer: 2*SYNC_STAGE+2 clocks plus peer latency.

Reset
REQ-023 Reset SHALL immediately force: all FSMs to IDLE/WAIT_REQ, all req/ack outputs 0, rx_valid 0, rx_data 0, rx_perr 0, async_tx_d 0, async_conf 0, synchronizers 0.
REQ-024 tx_ready and cfg_ready SHALL be 1 during and after reset (IDLE).
REQ-025 Reset mid-handshake SHALL abandon the transfer; the UART peer shares the same reset.

Structure
REQ-026 Handshake FSM state encodings and the 32-bit config bus width SHALL live in the shared uart package.
REQ-027 The initiator FSM plus its ack synchronizer SHALL be one sub-module, uart_hs_init, instantiated twice (tx, conf); the responder stays in the top.

Verification
REQ-028 tx_data=8'hA5 pulse with auto-ack peer (2-clock delay) -> async_tx_d=8'hA5, req rises 1 clk later, falls SYNC_STAGE+1 clks after ack, tx_ready back to 1 after ack falls.
REQ-029 cfg_data=8'h62 -> async_conf=32'h0000_0062 held across full 4-phase; cfg_ready=0 throughout.
REQ-030 async_rx_d=9'h13C, req=1, rx_ready=1 -> rx_data=8'h3C, rx_perr=1, ack=1 SYNC_STAGE+1 clks after req; ack=0 after req drops.
REQ-031 rx_ready=0, peer sends 8'h11 then 8'h22 -> second req unacked until rx_ready pulses; host sees 11 then 22, none lost.
REQ-032 Loopback (tx wired to rx in uart_top, conf 8'h62), 16 random bytes -> rx stream equals tx stream, rx_perr=0.
REQ-033 Assert reset while async_tx_d_req=1 and rx_valid=1 -> all req/ack/rx_valid 0 same cycle, tx_ready=1.
